burst_ctrl: RTL and testbench

BURST_CTRL -- requirements
Module: burst_ctrl

---
 rtl/burst_ctrl_if.sv | 46 ++++
 rtl/burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_burst_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_ctrl_if.sv
// Cache-side request/status and AXI burst channel bundle for burst_ctrl.
// The master modport is the controller's view; slave is the environment's view.
interface burst_ctrl_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  i_start_read;
    logic                  i_start_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  o_arvalid;
    logic                  i_arready;
    logic                  o_awvalid;
    logic                  i_awready;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [7:0]            o_len;
    logic                  i_rvalid;
    logic                  i_rlast;
    logic                  o_rready;
    logic                  o_wvalid;
    logic                  o_wlast;
    logic                  i_wready;
    logic                  i_bvalid;
    logic [1:0]            i_bresp;
    logic                  o_bready;
    logic                  o_fifo_write_en;
    logic                  o_fifo_start_read;
    logic                  o_fifo_start_write;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;

    modport master (
        input  i_start_read, i_start_write, i_addr, i_arready, i_awready,
               i_rvalid, i_rlast, i_wready, i_bvalid, i_bresp,
        output o_arvalid, o_awvalid, o_addr, o_len, o_rready, o_wvalid, o_wlast,
               o_bready, o_fifo_write_en, o_fifo_start_read, o_fifo_start_write,
               o_busy, o_done, o_error
    );

    modport slave (
        output i_start_read, i_start_write, i_addr, i_arready, i_awready,
               i_rvalid, i_rlast, i_wready, i_bvalid, i_bresp,
        input  o_arvalid, o_awvalid, o_addr, o_len, o_rready, o_wvalid, o_wlast,
               o_bready, o_fifo_write_en, o_fifo_start_read, o_fifo_start_write,
               o_busy, o_done, o_error
    );
endinterface

// File: rtl/burst_ctrl.sv
// AXI burst controller moving one cache block per refill/writeback; BLOCK_WIDTH/AXI_DATA_WIDTH
// must be a power of two. Define BURST_CTRL_ERR_CHECK_EN to flag RLAST/BRESP protocol errors.
module burst_ctrl #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 512,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic         i_clk,
    input  logic         i_arstn,
    burst_ctrl_if.master bus
);
    localparam int BEATS       = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        RDATA,
        AW,
        WDATA,
        BRESP,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beatCnt_q, beatCnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  isWrite_q, isWrite_d;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
            addr_q    <= '0;
            isWrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            addr_q    <= addr_d;
            isWrite_q <= isWrite_d;
        end
    end

    // Writeback wins over refill in IDLE so a dirty victim leaves before its replacement arrives.
    always_comb begin
        state_d                = state_q;
        beatCnt_d              = beatCnt_q;
        addr_d                 = addr_q;
        isWrite_d              = isWrite_q;
        bus.o_arvalid          = 1'b0;
        bus.o_awvalid          = 1'b0;
        bus.o_rready           = 1'b0;
        bus.o_wvalid           = 1'b0;
        bus.o_wlast            = 1'b0;
        bus.o_bready           = 1'b0;
        bus.o_fifo_write_en    = 1'b0;
        bus.o_fifo_start_read  = 1'b0;
        bus.o_fifo_start_write = 1'b0;
        bus.o_done             = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start_write) begin
                    state_d   = AW;
                    isWrite_d = 1'b1;
                    addr_d    = bus.i_addr & ALIGN_MASK;
                end else if (bus.i_start_read) begin
                    state_d   = AR;
                    isWrite_d = 1'b0;
                    addr_d    = bus.i_addr & ALIGN_MASK;
                end
            end
            AR: begin
                bus.o_arvalid         = 1'b1;
                bus.o_fifo_start_read = 1'b1;
                if (bus.i_arready) begin
                    state_d   = RDATA;
                    beatCnt_d = '0;
                end
            end
            RDATA: begin
                bus.o_rready          = 1'b1;
                bus.o_fifo_start_read = 1'b1;
                if (bus.i_rvalid) begin
                    bus.o_fifo_write_en = 1'b1;
                    beatCnt_d           = beatCnt_q + 1'b1;
                    if (beatCnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            AW: begin
                bus.o_awvalid          = 1'b1;
                bus.o_fifo_start_write = 1'b1;
                if (bus.i_awready) begin
                    state_d   = WDATA;
                    beatCnt_d = '0;
                end
            end
            WDATA: begin
                bus.o_wvalid           = 1'b1;
                bus.o_wlast            = (beatCnt_q == LAST_BEAT);
                bus.o_fifo_start_write = 1'b1;
                if (bus.i_wready) begin
                    bus.o_fifo_write_en = 1'b1;
                    beatCnt_d           = beatCnt_q + 1'b1;
                    if (beatCnt_q == LAST_BEAT) state_d = BRESP;
                end
            end
            BRESP: begin
                bus.o_bready           = 1'b1;
                bus.o_fifo_start_write = 1'b1;
                if (bus.i_bvalid) state_d = DONE;
            end
            DONE: begin
                bus.o_done             = 1'b1;
                bus.o_fifo_start_read  = ~isWrite_q;
                bus.o_fifo_start_write = isWrite_q;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy = (state_q != IDLE);
    assign bus.o_addr = addr_q;
    assign bus.o_len  = 8'(BEATS - 1);

`ifdef BURST_CTRL_ERR_CHECK_EN
    // Burst length is always set by the beat counter; RLAST/BRESP only raise a flag.
    always_comb begin
        bus.o_error = 1'b0;
        if (state_q == RDATA && bus.i_rvalid) begin
            bus.o_error = (bus.i_rlast != (beatCnt_q == LAST_BEAT));
        end else if (state_q == BRESP && bus.i_bvalid) begin
            bus.o_error = (bus.i_bresp != 2'b00);
        end
    end
`else
    assign bus.o_error = 1'b0;
`endif
endmodule

// File: tb/tb_burst_ctrl.sv
// Bench for burst_ctrl: directed refill/writeback/reset scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the controller.
module tb_burst_ctrl;
    localparam int BEATS = 16;
`ifdef BURST_CTRL_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    burst_ctrl_if #(.ADDR_WIDTH(64)) bus ();

    burst_ctrl #(
        .AXI_DATA_WIDTH(32),
        .BLOCK_WIDTH   (512),
        .ADDR_WIDTH    (64)
    ) dut (
        .i_clk  (clk),
        .i_arstn(arstn),
        .bus    (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: stage 0 idle, 1 address phase, 2 data beats, 3 write response, 4 done pulse.
    int          mStage = 0;
    bit          mWrite = 1'b0;
    int          mBeats = 0;
    logic [63:0] mAddr = '0;

    bit          sWe, sDone, sErr, sWlast, sArvalid, sAwvalid, sBready, sStartRead;
    bit          sStartWrite;
    logic [63:0] sAddr;
    bit          reqRead = 1'b0;
    bit          reqWrite = 1'b0;

    task automatic checkField(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic setIdle();
        bus.i_start_read  = 1'b0;
        bus.i_start_write = 1'b0;
        bus.i_addr        = '0;
        bus.i_arready     = 1'b0;
        bus.i_awready     = 1'b0;
        bus.i_rvalid      = 1'b0;
        bus.i_rlast       = 1'b0;
        bus.i_wready      = 1'b0;
        bus.i_bvalid      = 1'b0;
        bus.i_bresp       = 2'b00;
    endtask

    task automatic checkOutput();
        bit lastBeat, inData, eErr;
        #1;
        lastBeat = (mBeats == BEATS - 1);
        inData   = (mStage == 2);
        eErr = ERR_ON && ((inData && !mWrite && bus.i_rvalid && (bus.i_rlast != lastBeat)) ||
                          (mStage == 3 && bus.i_bvalid && bus.i_bresp != 2'b00));
        sWe         = bus.o_fifo_write_en;
        sDone       = bus.o_done;
        sErr        = bus.o_error;
        sWlast      = bus.o_wlast;
        sArvalid    = bus.o_arvalid;
        sAwvalid    = bus.o_awvalid;
        sBready     = bus.o_bready;
        sStartRead  = bus.o_fifo_start_read;
        sStartWrite = bus.o_fifo_start_write;
        sAddr       = bus.o_addr;
        checkField("arvalid", 64'(bus.o_arvalid), 64'(mStage == 1 && !mWrite));
        checkField("awvalid", 64'(bus.o_awvalid), 64'(mStage == 1 && mWrite));
        checkField("rready", 64'(bus.o_rready), 64'(inData && !mWrite));
        checkField("wvalid", 64'(bus.o_wvalid), 64'(inData && mWrite));
        checkField("wlast", 64'(bus.o_wlast), 64'(inData && mWrite && lastBeat));
        checkField("bready", 64'(bus.o_bready), 64'(mStage == 3));
        checkField("fifo_we", 64'(bus.o_fifo_write_en),
                   64'(inData && (mWrite ? bus.i_wready : bus.i_rvalid)));
        checkField("start_read", 64'(bus.o_fifo_start_read), 64'(mStage != 0 && !mWrite));
        checkField("start_write", 64'(bus.o_fifo_start_write), 64'(mStage != 0 && mWrite));
        checkField("busy", 64'(bus.o_busy), 64'(mStage != 0));
        checkField("done", 64'(bus.o_done), 64'(mStage == 4));
        checkField("error", 64'(bus.o_error), 64'(eErr));
        checkField("addr", bus.o_addr, mAddr);
        checkField("len", 64'(bus.o_len), 64'(BEATS - 1));
    endtask

    task automatic modelAdvance();
        if (!arstn) begin
            mStage = 0;
            mWrite = 1'b0;
            mBeats = 0;
            mAddr  = '0;
            return;
        end
        case (mStage)
            0: if (bus.i_start_write || bus.i_start_read) begin
                mWrite = bus.i_start_write;
                mAddr  = (bus.i_addr / 64) * 64;
                mStage = 1;
            end
            1: if (mWrite ? bus.i_awready : bus.i_arready) begin
                mStage = 2;
                mBeats = 0;
            end
            2: if (mWrite ? bus.i_wready : bus.i_rvalid) begin
                if (mBeats == BEATS - 1) mStage = mWrite ? 3 : 4;
                else mBeats++;
            end
            3: if (bus.i_bvalid) mStage = 4;
            default: mStage = 0;
        endcase
    endtask

    task automatic cycle();
        checkOutput();
        modelAdvance();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        if (mStage == 0 && !reqRead && !reqWrite) begin
            if ($urandom_range(0, 3) == 0) reqRead = 1'b1;
            if ($urandom_range(0, 3) == 0) reqWrite = 1'b1;
        end else if (mStage != 0 && mStage != 4 && $urandom_range(0, 31) == 0) begin
            reqRead  = 1'b0;
            reqWrite = 1'b0;
        end
        bus.i_start_read  = reqRead;
        bus.i_start_write = reqWrite;
        bus.i_addr        = {$urandom, $urandom};
        bus.i_arready     = 1'($urandom_range(0, 1));
        bus.i_awready     = 1'($urandom_range(0, 1));
        bus.i_rvalid      = 1'($urandom_range(0, 1));
        bus.i_wready      = 1'($urandom_range(0, 1));
        bus.i_bvalid      = 1'($urandom_range(0, 1));
        bus.i_bresp       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        if (mStage == 2 && mBeats == BEATS - 1) bus.i_rlast = ($urandom_range(0, 7) != 0);
        else bus.i_rlast = ($urandom_range(0, 7) == 0);
    endtask

    // Refill with arready on the second AR cycle and continuous rvalid; k=0 is AR entry.
    task automatic refillDirected(input logic [63:0] a, input int rlastAt, input int abortAt);
        int weCnt, doneAt, srCnt, errAt;
        weCnt = 0; doneAt = -1; srCnt = 0; errAt = -1;
        setIdle();
        bus.i_start_read = 1'b1;
        bus.i_addr       = a;
        cycle();
        for (int k = 0; k < 40; k++) begin
            bus.i_arready = (k == 1);
            bus.i_rvalid  = (k >= 2);
            bus.i_rlast   = (k == rlastAt);
            if (k == abortAt) begin
                #2 arstn = 1'b0;
                #1;
                checkField("rst_mid_outputs",
                           64'({bus.o_arvalid, bus.o_awvalid, bus.o_rready, bus.o_wvalid,
                                bus.o_wlast, bus.o_bready, bus.o_fifo_write_en,
                                bus.o_fifo_start_read, bus.o_fifo_start_write, bus.o_busy,
                                bus.o_done, bus.o_error}), 64'd0);
                checkField("rst_mid_addr", bus.o_addr, 64'd0);
                modelAdvance();
                @(negedge clk);
                setIdle();
                cycle();
                arstn = 1'b1;
                cycle();
                return;
            end
            cycle();
            if (sWe) weCnt++;
            if (sStartRead) srCnt++;
            if (sErr && errAt < 0) errAt = k;
            if (sDone) begin
                doneAt = k;
                break;
            end
        end
        bus.i_start_read = 1'b0;
        checkField("refill_beats", 64'(weCnt), 64'd16);
        checkField("refill_done_at", 64'(doneAt), 64'd18);
        checkField("refill_start_read_cycles", 64'(srCnt), 64'd19);
        checkField("refill_error_at", 64'(errAt), 64'((ERR_ON && rlastAt != 17) ? rlastAt : -1));
    endtask

    // Simultaneous requests at 0x1234: writeback with toggling wready first, then the refill.
    task automatic writebackDirected(input logic [1:0] resp);
        int weCnt, doneAt, wlastHits, wlastBad, brAt, errAt;
        weCnt = 0; doneAt = -1; wlastHits = 0; wlastBad = 0; brAt = -1; errAt = -1;
        setIdle();
        bus.i_start_read  = 1'b1;
        bus.i_start_write = 1'b1;
        bus.i_addr        = 64'h1234;
        cycle();
        for (int k = 0; k < 80; k++) begin
            bus.i_awready = (k == 0);
            bus.i_wready  = (k % 2 == 1);
            bus.i_bvalid  = 1'b1;
            bus.i_bresp   = resp;
            cycle();
            if (k == 0) begin
                checkField("wb_first_awvalid", 64'(sAwvalid), 64'd1);
                checkField("wb_first_arvalid", 64'(sArvalid), 64'd0);
                checkField("wb_aligned_addr", sAddr, 64'h1200);
            end
            if (sWlast && weCnt != 15) wlastBad++;
            if (sWlast && bus.i_wready) wlastHits++;
            if (sWe) weCnt++;
            if (sBready && brAt < 0) brAt = k;
            if (sErr && errAt < 0) errAt = k;
            if (sDone) begin
                doneAt = k;
                break;
            end
        end
        checkField("wb_beats", 64'(weCnt), 64'd16);
        checkField("wb_wlast_hits", 64'(wlastHits), 64'd1);
        checkField("wb_wlast_early", 64'(wlastBad), 64'd0);
        checkField("wb_bready_at", 64'(brAt), 64'd32);
        checkField("wb_done_at", 64'(doneAt), 64'd33);
        checkField("wb_error_at", 64'(errAt), 64'((ERR_ON && resp != 2'b00) ? 32 : -1));
        setIdle();
        bus.i_start_read = 1'b1;
        bus.i_addr       = 64'h1234;
        cycle();
        cycle();
        checkField("wb_then_ar", 64'(sArvalid), 64'd1);
        weCnt = 0; doneAt = -1;
        for (int k = 0; k < 40; k++) begin
            bus.i_arready = 1'b1;
            bus.i_rvalid  = 1'b1;
            bus.i_rlast   = (mStage == 2 && mBeats == BEATS - 1);
            cycle();
            if (sWe) weCnt++;
            if (sDone) begin
                doneAt = k;
                break;
            end
        end
        bus.i_start_read = 1'b0;
        checkField("followup_refill_beats", 64'(weCnt), 64'd16);
        checkField("followup_refill_done_at", 64'(doneAt), 64'd17);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the run completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setIdle();
        @(negedge clk);
        cycle();
        checkField("reset_busy", 64'(bus.o_busy), 64'd0);
        checkField("reset_addr", bus.o_addr, 64'd0);
        cycle();
        arstn = 1'b1;
        cycle();

        refillDirected(64'h8000_0047, 17, -1);
        writebackDirected(2'b00);
        refillDirected(64'h0000_ABCD, 17, 9);
        refillDirected(64'h0000_5555, 17, -1);
        refillDirected(64'h0000_0100, 7, -1);
        writebackDirected(2'b10);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            cycle();
            if (sDone) begin
                if (sStartWrite) reqWrite = 1'b0;
                else reqRead = 1'b0;
            end
        end

        setIdle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
